// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the LA32R instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
  localparam logic [31:0] INST_NOP     = 32'h0340_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  function automatic logic [31:0] word_align(logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// Synchronous FIFO with flush; used for both the fetch queue and the in-flight PC queue.
module if_fetch_stage_fetch_queue #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Flush wins over a same-cycle push or pop.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// LA32R fetch stage: issues SRAM-like instruction requests, queues responses for decode,
// and drops responses that belong to a redirected-away path.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  logic            req_q, req_d;
  logic            stale_req_q, stale_req_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d, pc_src;
  logic [CntW-1:0] discard_q, discard_d;
  logic [SumW-1:0] total_d;
  logic            accept, accept_stale, hold, live_resp, drop_resp, pop, pcq_push;

  fq_entry_t       fq_head, fq_push_data;
  logic            fq_full, fq_empty, pcq_full, pcq_empty;
  logic [CntW-1:0] fq_count, pcq_count;
  logic [31:0]     pcq_head;

  assign inst_req     = req_q;
  assign inst_addr    = addr_q;
  assign accept       = req_q && inst_addr_ok;
  assign hold         = req_q && !inst_addr_ok;
  assign live_resp    = inst_data_ok && !redirect_valid && (discard_q == '0);
  assign drop_resp    = inst_data_ok && !live_resp;
  assign pop          = !fq_empty && id_ready && !redirect_valid;
  assign pcq_push     = accept && !redirect_valid && !stale_req_q;
  assign fq_push_data = '{pc: pcq_head, inst: inst_rdata};

  if_fetch_stage_fetch_queue #(
    .Width($bits(fq_entry_t)),
    .Depth(FQ_DEPTH)
  ) u_fq (
    .clk_i      (cpu_clk),
    .rst_i      (cpu_rst),
    .flush_i    (redirect_valid),
    .push_i     (live_resp),
    .push_data_i(fq_push_data),
    .pop_i      (pop),
    .pop_data_o (fq_head),
    .full_o     (fq_full),
    .empty_o    (fq_empty),
    .count_o    (fq_count)
  );

  // PCs of live requests, popped in order as their responses arrive.
  if_fetch_stage_fetch_queue #(
    .Width(32),
    .Depth(FQ_DEPTH)
  ) u_pcq (
    .clk_i      (cpu_clk),
    .rst_i      (cpu_rst),
    .flush_i    (redirect_valid),
    .push_i     (pcq_push),
    .push_data_i(addr_q),
    .pop_i      (live_resp),
    .pop_data_o (pcq_head),
    .full_o     (pcq_full),
    .empty_o    (pcq_empty),
    .count_o    (pcq_count)
  );

  always_comb begin
    pc_src       = redirect_valid ? word_align(redirect_pc) : fetch_pc_q;
    accept_stale = accept && stale_req_q && !redirect_valid;
    discard_d    = discard_q - CntW'(drop_resp) + CntW'(accept_stale);
    // Slots in use next cycle: queued, live in flight, and still to be discarded.
    total_d      = SumW'(fq_count) + SumW'(pcq_count) + SumW'(discard_q) + SumW'(accept)
                 - SumW'(pop) - SumW'(drop_resp);
    if (redirect_valid) begin
      discard_d = discard_q - CntW'(drop_resp) + pcq_count + CntW'(accept);
      total_d   = SumW'(discard_d);
    end

    req_d       = hold;
    addr_d      = addr_q;
    fetch_pc_d  = pc_src;
    stale_req_d = hold && (stale_req_q || redirect_valid);
    if (!hold) begin
      req_d  = (total_d < SumW'(FQ_DEPTH));
      addr_d = pc_src;
      if (req_d) fetch_pc_d = pc_src + 32'd4;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      req_q       <= 1'b0;
      stale_req_q <= 1'b0;
      addr_q      <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      discard_q   <= '0;
    end else begin
      req_q       <= req_d;
      stale_req_q <= stale_req_d;
      addr_q      <= addr_d;
      fetch_pc_q  <= fetch_pc_d;
      discard_q   <= discard_d;
    end
  end

  assign if_valid = !fq_empty;
  assign if_pc    = if_valid ? fq_head.pc : 32'h0;
  assign if_inst  = if_valid ? fq_head.inst : INST_NOP;

  assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    !(live_resp && (fq_full || pcq_empty)));
  assert property (@(posedge cpu_clk) disable iff (cpu_rst) !(pcq_push && pcq_full));
  assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    (SumW'(discard_q) + SumW'(pcq_count)) <= SumW'(FQ_DEPTH));

endmodule
